// File: rtl/mem_burst_responder.sv
// Four-beat critical-word-first burst responder between a cache and a 1-cycle backing SRAM.
// Optional sticky protocol-error detection enabled by defining MEM_RESP_REQ_ERR_EN.
module mem_burst_responder #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_wren,
  input  logic [31:0]       mem_address,
  input  logic [15:0]       to_mem,
  output logic [15:0]       from_mem,
  output logic [1:0]        mem_offset,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  output logic              sram_we,
  input  logic [15:0]       sram_rdata,
  output logic              req_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_PRE  = 2'd2,
    S_BEAT = 2'd3
  } state_t;

  // S_WAIT counts down from this value to zero, giving LATENCY-1 wait cycles
  localparam int         WAIT_INIT_I = (LATENCY > 32'sd1) ? (LATENCY - 32'sd2) : 32'sd0;
  localparam logic [3:0] WAIT_INIT   = 4'(WAIT_INIT_I);

  state_t            state_r, state_s;
  logic [1:0]        k_r, k_s;
  logic [3:0]        cnt_r, cnt_s;
  logic [ADDR_W-3:0] hi_r, hi_s;
  logic [1:0]        base_r, base_s;
  logic              wren_r, wren_s;
  logic              unused_addr_s;

  assign unused_addr_s = ^mem_address;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-3:0] hi,
                                                  input logic [1:0] base,
                                                  input logic [1:0] k);
    return {hi, base ^ k};
  endfunction

  // State and burst-context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      k_r     <= 2'd0;
      cnt_r   <= 4'd0;
      hi_r    <= '0;
      base_r  <= 2'd0;
      wren_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      cnt_r   <= cnt_s;
      hi_r    <= hi_s;
      base_r  <= base_s;
      wren_r  <= wren_s;
    end
  end

  // Next-state logic; requests outside S_IDLE are dropped
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    cnt_s   = cnt_r;
    hi_s    = hi_r;
    base_s  = base_r;
    wren_s  = wren_r;
    case (state_r)
      S_IDLE: begin
        if (mem_req) begin
          hi_s    = mem_address[ADDR_W-1:2];
          base_s  = mem_address[1:0];
          wren_s  = mem_wren;
          cnt_s   = WAIT_INIT;
          k_s     = 2'd0;
          state_s = (LATENCY == 32'sd1) ? S_PRE : S_WAIT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = S_PRE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      S_PRE: begin
        state_s = S_BEAT;
        k_s     = 2'd0;
      end
      S_BEAT: begin
        if (k_r == 2'd3) begin
          state_s = S_IDLE;
          k_s     = 2'd0;
        end else begin
          k_s = k_r + 2'd1;
        end
      end
      default: begin
        state_s = S_IDLE;
        k_s     = 2'd0;
      end
    endcase
  end

  // Cache and SRAM port decode; fetch addresses run one beat ahead of the data
  always_comb begin
    from_mem   = 16'd0;
    mem_offset = 2'd0;
    mem_ready  = 1'b0;
    sram_addr  = word_addr(hi_r, base_r, k_r);
    sram_wdata = to_mem;
    sram_we    = 1'b0;
    case (state_r)
      S_PRE: begin
        sram_addr  = word_addr(hi_r, base_r, 2'd0);
        mem_offset = 2'd0;
      end
      S_BEAT: begin
        mem_ready = 1'b1;
        if (wren_r) begin
          sram_we    = 1'b1;
          sram_addr  = word_addr(hi_r, base_r, k_r);
          mem_offset = (k_r == 2'd3) ? 2'd3 : (k_r + 2'd1);
        end else begin
          from_mem   = sram_rdata;
          mem_offset = k_r;
          if (k_r != 2'd3) begin
            sram_addr = word_addr(hi_r, base_r, k_r + 2'd1);
          end else begin
            sram_addr = word_addr(hi_r, base_r, k_r);
          end
        end
      end
      default: begin
        mem_ready = 1'b0;
      end
    endcase
  end

`ifdef MEM_RESP_REQ_ERR_EN
  logic req_err_r;

  // Sticky flag for a request seen while a burst is in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      req_err_r <= 1'b0;
    end else if (mem_req && (state_r != S_IDLE)) begin
      req_err_r <= 1'b1;
    end
  end

  assign req_err = req_err_r;
`else
  assign req_err = 1'b0;
`endif

endmodule

// File: doc/mem_burst_responder.md
MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the width of the backing-SRAM word address.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning cycles from request sample to the PRE state, legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port mem_req, input, 1 bit: one-cycle burst request pulse from the cache.
REQ-006 The block SHALL have port mem_wren, input, 1 bit: 1 = writeback burst, 0 = fetch burst; valid with mem_req.
REQ-007 The block SHALL have port mem_address, input, 32 bits: 16-bit-word address; [1:0] selects the critical word.
REQ-008 The block SHALL have port to_mem, input, 16 bits: writeback data from the cache.
REQ-009 The block SHALL have port from_mem, output, 16 bits: fetch data to the cache.
REQ-010 The block SHALL have port mem_offset, output, 2 bits: beat offset; the cache XORs it with address[1:0].
REQ-011 The block SHALL have port mem_ready, output, 1 bit: beat-valid window; its falling edge marks burst done.
REQ-012 The block SHALL have port sram_addr, output, ADDR_W bits: backing-SRAM word address.
REQ-013 The block SHALL have port sram_wdata, output, 16 bits: backing-SRAM write data.
REQ-014 The block SHALL have port sram_we, output, 1 bit: backing-SRAM write enable.
REQ-015 The block SHALL have port sram_rdata, input, 16 bits: backing-SRAM read data, 1-cycle latency from sram_addr.
REQ-016 The block SHALL have port req_err, output, 1 bit: sticky protocol-error flag (see Configuration).

Function
REQ-017 The states SHALL be S_IDLE, S_WAIT, S_PRE and S_BEAT; a 2-bit beat counter k runs 0..3 in S_BEAT.
REQ-018 In S_IDLE, mem_req=1 SHALL latch mem_address, mem_wren and base=mem_address[1:0], then go to S_PRE if LATENCY==1, else to S_WAIT.
REQ-019 S_WAIT SHALL last LATENCY-1 cycles, then go to S_PRE; S_PRE SHALL last 1 cycle, then go to S_BEAT with k=0.
REQ-020 S_BEAT SHALL last exactly 4 cycles (k=0..3), then go to S_IDLE; mem_ready=1 only in S_BEAT.
REQ-021 First mem_ready SHALL occur in cycle T+1+LATENCY, where T is the request cycle.
REQ-022 Beat k word address SHALL be {latched[ADDR_W-1:2], base^k}; bits above ADDR_W are ignored.
REQ-023 Fetch burst: S_PRE SHALL drive sram_addr=word(0).
REQ-024 Fetch burst: in beat k, from_mem=sram_rdata (word k), mem_offset=k, and sram_addr=word(k+1) for k<3.
REQ-025 Fetch burst: sram_we SHALL stay 0 throughout.
REQ-026 Writeback burst: mem_offset SHALL lead by one cycle, giving 0 in S_PRE, k+1 in beat k<3, and 3 in beat 3.
REQ-027 Writeback burst: in beat k, sram_we=1, sram_addr=word(k), sram_wdata=to_mem.
REQ-028 from_mem SHALL be 0 outside fetch beats; mem_offset SHALL be 0 in S_IDLE and S_WAIT; sram_we SHALL be 0 outside writeback beats.
REQ-029 mem_req outside S_IDLE SHALL be ignored, with no queueing.
REQ-030 mem_req in the S_IDLE cycle directly after beat 3 SHALL be accepted, so back-to-back writeback then fetch bursts work.
REQ-031 mem_wren and mem_address SHALL be sampled only with an accepted mem_req.

Reset
REQ-032 When rst=1, state SHALL become S_IDLE, k=0, and mem_ready, sram_we, from_mem, mem_offset and req_err SHALL be 0 from the next cycle.
REQ-033 rst mid-burst SHALL abort the burst immediately; beats already written SHALL remain, and no further sram_we SHALL be issued.
REQ-034 rst SHALL take priority over a simultaneous mem_req, which is dropped.

Configuration
REQ-035 Macro MEM_RESP_REQ_ERR_EN defined: req_err SHALL set on any mem_req sampled outside S_IDLE and hold until rst.
REQ-036 Macro MEM_RESP_REQ_ERR_EN undefined: req_err SHALL be constant 0, with no detection logic.

Verification
REQ-037 LATENCY=2, SRAM[0x100..0x103]=A0,A1,A2,A3, fetch request at 0x102 in cycle 0 -> mem_ready in cycles 3-6; from_mem A2,A3,A0,A1 with mem_offset 0,1,2,3.
REQ-038 Writeback request at 0x201 with cache words W0..W3 -> SRAM 0x201,0x200,0x203,0x202 written in beats 0-3 with the to_mem values; mem_offset 0,1,2,3,3 across S_PRE and beats.
REQ-039 Writeback at 0x40 followed by fetch request in the first S_IDLE cycle -> second burst accepted; mem_ready low exactly 1+LATENCY cycles between bursts.
REQ-040 rst asserted during writeback beat 1 -> only 2 SRAM writes occur; mem_ready and sram_we are 0 from the next cycle; a later request is served normally.
REQ-041 mem_req pulsed during S_WAIT -> ignored and burst unaffected; req_err=1 with MEM_RESP_REQ_ERR_EN defined, 0 without.
REQ-042 LATENCY=1 and LATENCY=15 fetch -> first mem_ready in cycle T+2 and T+16 respectively.
